// File: rtl/issue_rr_arbiter_pkg.sv
// Shared sizing for the issue arbiter: wavefront slot count, id width and slot-id helpers.
package issue_rr_arbiter_pkg;

  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;

  // Ids at or above WF_PER_CU decode to an empty mask so out-of-range flushes are no-ops.
  function automatic logic [WF_PER_CU-1:0] onehot(input logic [WF_ID_LENGTH-1:0] id);
    onehot = '0;
    if (int'(id) < WF_PER_CU) onehot[id] = 1'b1;
  endfunction

  function automatic logic [WF_ID_LENGTH-1:0] wrap_inc(input logic [WF_ID_LENGTH-1:0] id);
    wrap_inc = (id == WF_ID_LENGTH'(WF_PER_CU - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/issue_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping modulo N.
// Zero latency; no flow control.
module issue_rr_arbiter_rr_pick
  import issue_rr_arbiter_pkg::*;
#(
  parameter int N = WF_PER_CU,
  parameter int W = WF_ID_LENGTH
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] id
);

  logic [N-1:0] rot;
  logic [W-1:0] k;
  logic [W:0]   sum;

  always_comb begin
    rot   = N'({req, req} >> start);
    found = |rot;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = W'(i);
    end
    sum = (W+1)'(k) + (W+1)'(start);
    id  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  end

endmodule

// File: rtl/issue_rr_arbiter.sv
// Round-robin wavefront issue arbiter; offer registered 1 cycle after a candidate appears, 1 issue/cycle.
// Offer held under fu_ready=0 unless withdrawn by flush or valid-entry clear. Optional ISSUE_ARB_PERF_EN counters.
module issue_rr_arbiter
  import issue_rr_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    valid_entry_in,
  input  logic [WF_PER_CU-1:0]    ready_mask_in,
  input  logic                    fu_ready,
  input  logic                    flush_en,
  input  logic [WF_ID_LENGTH-1:0] flush_wfid,
  output logic                    issue_valid,
  output logic [WF_ID_LENGTH-1:0] issue_wfid,
  output logic                    issued_valid,
  output logic [WF_ID_LENGTH-1:0] issued_wfid
`ifdef ISSUE_ARB_PERF_EN
  ,
  output logic [31:0]             perf_issue_count,
  output logic [31:0]             perf_stall_count
`endif
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t                  state;
  logic [WF_ID_LENGTH-1:0] ptr;
  logic [WF_PER_CU-1:0]    cand;
  logic [WF_PER_CU-1:0]    cand_excl;
  logic [WF_PER_CU-1:0]    req_a;
  logic                    withdraw;
  logic                    found_a, found_b;
  logic [WF_ID_LENGTH-1:0] id_a, id_b;

  assign cand      = valid_entry_in & ready_mask_in & ~(flush_en ? onehot(flush_wfid) : '0);
  assign cand_excl = cand & ~onehot(issue_wfid);
  // While offering, the idle/withdraw pick must never re-select the current offer.
  assign req_a     = (state == OFFER) ? cand_excl : cand;
  assign withdraw  = (flush_en && flush_wfid == issue_wfid) || !valid_entry_in[issue_wfid];

  assign issued_valid = issue_valid & fu_ready;
  assign issued_wfid  = issue_wfid;

  issue_rr_arbiter_rr_pick u_pick_idle (
    .req   (req_a),
    .start (wrap_inc(ptr)),
    .found (found_a),
    .id    (id_a)
  );

  issue_rr_arbiter_rr_pick u_pick_next (
    .req   (cand_excl),
    .start (wrap_inc(issue_wfid)),
    .found (found_b),
    .id    (id_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_wfid  <= '0;
      ptr         <= WF_ID_LENGTH'(WF_PER_CU - 1);
    end else if (state == IDLE) begin
      if (found_a) begin
        issue_wfid  <= id_a;
        issue_valid <= 1'b1;
        state       <= OFFER;
      end
    end else if (fu_ready) begin
      // Accept outranks a same-cycle withdrawal: dispatch has already taken it.
      ptr <= issue_wfid;
      if (found_b) begin
        issue_wfid <= id_b;
      end else begin
        issue_valid <= 1'b0;
        state       <= IDLE;
      end
    end else if (withdraw) begin
      if (found_a) begin
        issue_wfid <= id_a;
      end else begin
        issue_valid <= 1'b0;
        state       <= IDLE;
      end
    end
  end

`ifdef ISSUE_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (issued_valid && perf_issue_count != 32'hFFFF_FFFF)
        perf_issue_count <= perf_issue_count + 32'd1;
      if (issue_valid && !fu_ready && perf_stall_count != 32'hFFFF_FFFF)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_rr_arbiter.sv
// Bench for issue_rr_arbiter: directed scenarios plus randomized traffic against a slot-level model.
module tb_issue_rr_arbiter;
  import issue_rr_arbiter_pkg::*;

  localparam int N = WF_PER_CU;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            valid_entry_in;
  logic [N-1:0]            ready_mask_in;
  logic                    fu_ready;
  logic                    flush_en;
  logic [WF_ID_LENGTH-1:0] flush_wfid;
  logic                    issue_valid;
  logic [WF_ID_LENGTH-1:0] issue_wfid;
  logic                    issued_valid;
  logic [WF_ID_LENGTH-1:0] issued_wfid;
`ifdef ISSUE_ARB_PERF_EN
  logic [31:0]             perf_issue_count;
  logic [31:0]             perf_stall_count;
`endif

  issue_rr_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .valid_entry_in (valid_entry_in),
    .ready_mask_in  (ready_mask_in),
    .fu_ready       (fu_ready),
    .flush_en       (flush_en),
    .flush_wfid     (flush_wfid),
    .issue_valid    (issue_valid),
    .issue_wfid     (issue_wfid),
    .issued_valid   (issued_valid),
    .issued_wfid    (issued_wfid)
`ifdef ISSUE_ARB_PERF_EN
    ,
    .perf_issue_count (perf_issue_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: offer flag, offered slot, last-accepted slot, perf tallies.
  bit          m_valid;
  int          m_wfid;
  int          m_ptr;
  int unsigned m_iss, m_stl;

  // Mid-cycle samples of the combinational handshake and what the model expected for it.
  logic                    s_iv;
  logic [WF_ID_LENGTH-1:0] s_iw;
  bit                      e_iv;
  int                      e_iw;

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int m_pick(input bit [N-1:0] req, input int from);
    for (int k = 0; k < N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wfid = 0; m_ptr = N - 1; m_iss = 0; m_stl = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_entry_in = '0; ready_mask_in = '0; fu_ready = 1'b0; flush_en = 1'b0; flush_wfid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_cycle(input logic [N-1:0] ve, input logic [N-1:0] rm, input logic fr,
                             input logic fe, input logic [WF_ID_LENGTH-1:0] fw);
    bit [N-1:0] cand, c2;
    int p, nw, np;
    bit nv;
    @(negedge clk);
    valid_entry_in = ve; ready_mask_in = rm; fu_ready = fr; flush_en = fe; flush_wfid = fw;
    #1;
    s_iv = issued_valid;
    s_iw = issued_wfid;
    e_iv = m_valid && fr;
    e_iw = m_wfid;
    cand = ve & rm;
    if (fe && int'(fw) < N) cand[fw] = 1'b0;
    nv = m_valid; nw = m_wfid; np = m_ptr;
    if (!m_valid) begin
      p = m_pick(cand, (m_ptr + 1) % N);
      if (p >= 0) begin nv = 1; nw = p; end
    end else if (fr) begin
      m_iss++;
      np = m_wfid;
      c2 = cand; c2[m_wfid] = 1'b0;
      p  = m_pick(c2, (m_wfid + 1) % N);
      nv = (p >= 0);
      if (p >= 0) nw = p;
    end else begin
      m_stl++;
      if ((fe && int'(fw) == m_wfid) || !ve[m_wfid]) begin
        c2 = cand; c2[m_wfid] = 1'b0;
        p  = m_pick(c2, (m_ptr + 1) % N);
        nv = (p >= 0);
        if (p >= 0) nw = p;
      end
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_wfid = nw; m_ptr = np;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_entry_in = '0; ready_mask_in = '0; fu_ready = 1'b1; flush_en = 1'b0; flush_wfid = '0;
    #1;
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", issue_valid); end
    n_cmp++; if (issue_wfid !== '0) begin n_bad++; $display("FAIL reset_wfid got=%0d want=0", issue_wfid); end
    n_cmp++; if (issued_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issued got=%b want=0", issued_valid); end
`ifdef ISSUE_ARB_PERF_EN
    n_cmp++; if (perf_issue_count !== 32'd0 || perf_stall_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_issue_count, perf_stall_count);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [N-1:0] b;
    do_reset();
    b = bitv(5);
    drive_cycle(b, b, 1'b1, 1'b0, '0);
    n_cmp++; if (s_iv !== 1'b0) begin n_bad++; $display("FAIL single_pre_issued got=%b want=0", s_iv); end
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd5) begin
      n_bad++; $display("FAIL single_offer got=%b/%0d want=1/5", issue_valid, issue_wfid);
    end
    drive_cycle(b, b, 1'b1, 1'b0, '0);
    n_cmp++; if (s_iv !== 1'b1 || s_iw !== 6'd5) begin
      n_bad++; $display("FAIL single_issued got=%b/%0d want=1/5", s_iv, s_iw);
    end
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle got=%b want=0", issue_valid); end
    b = bitv(4) | bitv(6);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd6) begin
      n_bad++; $display("FAIL single_ptr_advance got=%b/%0d want=1/6", issue_valid, issue_wfid);
    end
  endtask

  task automatic test_rr_wrap();
    logic [N-1:0] b;
    int exp_ids[5] = '{3, 10, 39, 3, 10};
    do_reset();
    b = bitv(3) | bitv(10) | bitv(39);
    drive_cycle(b, b, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(b, b, 1'b1, 1'b0, '0);
      n_cmp++; if (s_iv !== 1'b1 || int'(s_iw) != exp_ids[i]) begin
        n_bad++; $display("FAIL rr_wrap[%0d] got=%b/%0d want=1/%0d", i, s_iv, s_iw, exp_ids[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] b;
    do_reset();
    b = bitv(7);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      // Readiness dropping mid-offer must not withdraw it.
      drive_cycle(b, (i == 2) ? '0 : b, 1'b0, 1'b0, '0);
      n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd7 || s_iv !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d] got=%b/%0d/%b want=1/7/0", i, issue_valid, issue_wfid, s_iv);
      end
    end
    drive_cycle(b, b, 1'b1, 1'b0, '0);
    n_cmp++; if (s_iv !== 1'b1 || s_iw !== 6'd7) begin
      n_bad++; $display("FAIL stall_accept got=%b/%0d want=1/7", s_iv, s_iw);
    end
`ifdef ISSUE_ARB_PERF_EN
    n_cmp++; if (perf_stall_count !== 32'd4 || perf_issue_count !== 32'd1) begin
      n_bad++; $display("FAIL stall_perf got=%0d/%0d want=4/1", perf_stall_count, perf_issue_count);
    end
`endif
  endtask

  task automatic test_flush();
    logic [N-1:0] b;
    do_reset();
    b = bitv(12) | bitv(20);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_wfid !== 6'd12) begin n_bad++; $display("FAIL flush_offer got=%0d want=12", issue_wfid); end
    drive_cycle(b, b, 1'b0, 1'b1, 6'd12);
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd20) begin
      n_bad++; $display("FAIL flush_repick got=%b/%0d want=1/20", issue_valid, issue_wfid);
    end
    drive_cycle(bitv(20), bitv(20), 1'b1, 1'b0, '0);
    n_cmp++; if (s_iv !== 1'b1 || s_iw !== 6'd20 || issue_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_after got=%b/%0d/%b want=1/20/0", s_iv, s_iw, issue_valid);
    end
    do_reset();
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    drive_cycle(b, b, 1'b1, 1'b1, 6'd12);
    n_cmp++; if (s_iv !== 1'b1 || s_iw !== 6'd12) begin
      n_bad++; $display("FAIL flush_accept_wins got=%b/%0d want=1/12", s_iv, s_iw);
    end
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd20) begin
      n_bad++; $display("FAIL flush_accept_next got=%b/%0d want=1/20", issue_valid, issue_wfid);
    end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] b;
    do_reset();
    b = bitv(2);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    drive_cycle('0, '0, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL withdraw_idle got=%b want=0", issue_valid); end
    b = bitv(1) | bitv(3);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd1) begin
      n_bad++; $display("FAIL withdraw_ptr_kept got=%b/%0d want=1/1", issue_valid, issue_wfid);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] b;
    do_reset();
    b = bitv(30);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    drive_cycle(b, b, 1'b1, 1'b0, '0);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd30) begin
      n_bad++; $display("FAIL async_offer got=%b/%0d want=1/30", issue_valid, issue_wfid);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL async_drop got=%b want=0", issue_valid); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    b = bitv(8) | bitv(35);
    drive_cycle(b, b, 1'b0, 1'b0, '0);
    n_cmp++; if (issue_valid !== 1'b1 || issue_wfid !== 6'd8) begin
      n_bad++; $display("FAIL async_first got=%b/%0d want=1/8", issue_valid, issue_wfid);
    end
  endtask

  task automatic test_random();
    logic [63:0] t;
    logic [N-1:0] ve, rm;
    logic fr, fe;
    logic [WF_ID_LENGTH-1:0] fw;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      t  = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      ve = t[N-1:0];
      t  = ~({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
      rm = t[N-1:0];
      fr = ($urandom_range(0, 3) != 0);
      fe = ($urandom_range(0, 5) == 0);
      fw = ($urandom_range(0, 1) == 0) ? WF_ID_LENGTH'(m_wfid) : WF_ID_LENGTH'($urandom_range(0, 63));
      drive_cycle(ve, rm, fr, fe, fw);
      n_cmp++; if (s_iv !== e_iv || (e_iv && int'(s_iw) != e_iw)) begin
        n_bad++; $display("FAIL rand_issued[%0d] got=%b/%0d want=%b/%0d", c, s_iv, s_iw, e_iv, e_iw);
      end
      n_cmp++; if (issue_valid !== m_valid || (m_valid && int'(issue_wfid) != m_wfid)) begin
        n_bad++; $display("FAIL rand_offer[%0d] got=%b/%0d want=%b/%0d", c, issue_valid, issue_wfid, m_valid, m_wfid);
      end
    end
`ifdef ISSUE_ARB_PERF_EN
    n_cmp++; if (perf_issue_count !== m_iss || perf_stall_count !== m_stl) begin
      n_bad++; $display("FAIL rand_perf got=%0d/%0d want=%0d/%0d", perf_issue_count, perf_stall_count, m_iss, m_stl);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    valid_entry_in = '0; ready_mask_in = '0; fu_ready = 1'b0; flush_en = 1'b0; flush_wfid = '0;
    model_reset();
    test_reset();
    test_single();
    test_rr_wrap();
    test_stall();
    test_flush();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_rr_arbiter.md
Name: issue_rr_arbiter

Overview:
- Round-robin issue arbiter for one compute unit.
- Takes the per-wavefront valid-entry vector (set at decode, cleared at issue or taken branch) and a per-wavefront operand-ready mask.
- Selects one eligible wavefront and presents it to the functional-unit dispatch stage with a valid/ready handshake.
- Its accepted-issue outputs are the issued_valid/issued_wfid clear inputs of the valid-entry tracker.

Parameters:
- WF_PER_CU, 40, number of wavefront slots.
- WF_ID_LENGTH, 6, width of a wavefront id.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- valid_entry_in  input  WF_PER_CU  per-wavefront instruction-valid vector.
- ready_mask_in  input  WF_PER_CU  per-wavefront operands/resources ready.
- fu_ready  input  1  dispatch stage accepts the current offer this cycle.
- flush_en  input  1  squash request (e.g. taken branch).
- flush_wfid  input  WF_ID_LENGTH  wavefront being squashed.
- issue_valid  output  1  offer present.
- issue_wfid  output  WF_ID_LENGTH  offered wavefront id.
- issued_valid  output  1  combinational: issue_valid & fu_ready; feeds the valid-entry clear.
- issued_wfid  output  WF_ID_LENGTH  equals issue_wfid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, issue_valid=0, issue_wfid=0.
  - last-grant pointer ptr = WF_PER_CU-1, so the first search starts at slot 0.
- Candidate vector: cand = valid_entry_in & ready_mask_in & ~(flush_en ? onehot(flush_wfid) : 0).
- Pick: the first set bit of cand scanning ptr+1, ptr+2, ... with wrap modulo WF_PER_CU (39 wraps to 0, not to 63). Ids 40..63 are never produced.
- State IDLE:
  - If cand != 0, register pick into issue_wfid, set issue_valid=1, go to OFFER.
  - Latency from candidate becoming set to issue_valid is 1 cycle.
  - Otherwise remain in IDLE.
- State OFFER:
  - issue_wfid is held stable while issue_valid=1 && fu_ready=0, except on withdrawal (below).
  - Accept (fu_ready=1):
    - ptr <= issue_wfid.
    - Recompute the pick with the accepted bit masked off, searching from issue_wfid+1.
    - If a candidate remains, load it and stay in OFFER (back-to-back issue, 1 per cycle). Otherwise issue_valid <= 0 and go to IDLE.
  - Withdrawal: if (flush_en && flush_wfid == issue_wfid) or valid_entry_in[issue_wfid]==0, while fu_ready=0:
    - Drop the offer. A new pick from cand (excluding the withdrawn id) is loaded next cycle if one exists; otherwise go to IDLE.
    - ptr is unchanged.
  - Withdrawal and fu_ready=1 in the same cycle: the accept wins. The dispatch stage has already sampled it, and issued_valid=1 is asserted.
- The pointer advances only on accept, which guarantees fairness: every continuously-eligible wavefront is granted within WF_PER_CU accepts.
- flush_wfid >= WF_PER_CU: the flush is ignored.
- ready_mask_in dropping for the offered id does not withdraw the offer; readiness is sampled only at pick time.

Optional Feature:
- Macro: ISSUE_ARB_PERF_EN.
- When defined, two extra outputs are added:
  - perf_issue_count [31:0]: increments on each accept.
  - perf_stall_count [31:0]: increments each cycle with issue_valid=1 and fu_ready=0.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- WF_PER_CU and WF_ID_LENGTH come from the shared global definitions include; no local redefinition.
- State encoding (IDLE=1'b0, OFFER=1'b1) is a local constant in the module.
- One sub-module: rr_pick (inputs: request vector, start pointer, WF_PER_CU; outputs: found flag, WF_ID_LENGTH-bit id). It is a purely combinational rotate, priority-encode and unrotate, instantiated twice: one idle/withdraw pick and one post-accept pick.

Test Plan:
- Reset, then valid_entry=ready=bit5 only, fu_ready=1 → issue_valid=1, issue_wfid=5 one cycle later; issued_valid pulses; ptr=5; next cycle issue_valid=0.
- Bits 3,10,39 eligible and held, fu_ready=1 constant → grants 3,10,39,3,10 on consecutive cycles (wrap 39→3).
- Offer wfid 7, fu_ready=0 for 4 cycles → issue_wfid stays 7 and issue_valid=1 throughout; accept on cycle 5; (PERF) stall_count=4, issue_count=1.
- Offering wfid 12, flush_en=1, flush_wfid=12, fu_ready=0, with 20 also eligible → next cycle issue_wfid=20 and wfid 12 is never issued; repeat with fu_ready=1 in the flush cycle → 12 is issued.
- Offering wfid 2, valid_entry[2] cleared, fu_ready=0, no other candidates → issue_valid=0 next cycle, state IDLE, ptr unchanged.
- Assert rst mid-OFFER (wfid 30) → issue_valid=0 immediately (async); after release, the first grant is the lowest eligible id ≥ 0.
